// File: rtl/multiport_reg_file_if.sv
// Bus bundle for the three-read / two-write register file with pending scoreboard.
// master drives addresses, writes and scoreboard sets; slave is the register file.
interface multiport_reg_file_if #(
   parameter int WORD_LEN = 32,
   parameter int ADDR_LEN = 4
);
   logic                init_busy;
   logic [ADDR_LEN-1:0] rd_addr_a;
   logic [ADDR_LEN-1:0] rd_addr_b;
   logic [ADDR_LEN-1:0] rd_addr_c;
   logic [WORD_LEN-1:0] rd_data_a;
   logic [WORD_LEN-1:0] rd_data_b;
   logic [WORD_LEN-1:0] rd_data_c;
   logic                rd_pend_a;
   logic                rd_pend_b;
   logic                rd_pend_c;
   logic                wr_en0;
   logic [ADDR_LEN-1:0] wr_addr0;
   logic [WORD_LEN-1:0] wr_data0;
   logic                wr_en1;
   logic [ADDR_LEN-1:0] wr_addr1;
   logic [WORD_LEN-1:0] wr_data1;
   logic                sb_set;
   logic [ADDR_LEN-1:0] sb_set_addr;
   logic                wr_conflict;

   modport master (
      input  init_busy, rd_data_a, rd_data_b, rd_data_c,
             rd_pend_a, rd_pend_b, rd_pend_c, wr_conflict,
      output rd_addr_a, rd_addr_b, rd_addr_c,
             wr_en0, wr_addr0, wr_data0, wr_en1, wr_addr1, wr_data1,
             sb_set, sb_set_addr
   );

   modport slave (
      output init_busy, rd_data_a, rd_data_b, rd_data_c,
             rd_pend_a, rd_pend_b, rd_pend_c, wr_conflict,
      input  rd_addr_a, rd_addr_b, rd_addr_c,
             wr_en0, wr_addr0, wr_data0, wr_en1, wr_addr1, wr_data1,
             sb_set, sb_set_addr
   );
endinterface

// File: rtl/multiport_reg_file.sv
// Register file: 3 combinational read ports with write-through bypass, 2 write ports
// (port 0 wins on collision), a pending scoreboard, and an init sweep after reset.
module multiport_reg_file #(
   parameter int WORD_LEN   = 32,
   parameter int WORD_COUNT = 16,
   parameter int ADDR_LEN   = 4,
   parameter int INIT_INDEX = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   multiport_reg_file_if.slave     bus
);
   localparam logic [0:0]          ST_INIT = 1'b0;
   localparam logic [0:0]          ST_RUN  = 1'b1;
   localparam logic [ADDR_LEN-1:0] LAST    = ADDR_LEN'(WORD_COUNT - 1);

   logic [0:0]          state;
   logic [ADDR_LEN-1:0] cnt;
   logic [WORD_LEN-1:0] mem [WORD_COUNT];
   logic [WORD_COUNT-1:0] sb;
   logic [WORD_COUNT-1:0] sb_nxt;
   logic                conflict;
   logic                run;
   logic                we0;
   logic                we1;
   logic                set_ok;
   logic                conflict_nxt;
   logic [ADDR_LEN-1:0] ra [3];
   logic [WORD_LEN-1:0] rd [3];
   logic                pd [3];

   function automatic logic addr_ok(input logic [ADDR_LEN-1:0] a);
      return {1'b0, a} < (ADDR_LEN + 1)'(WORD_COUNT);
   endfunction

   assign run          = (state == ST_RUN);
   assign conflict_nxt = run && bus.wr_en0 && bus.wr_en1 && addr_ok(bus.wr_addr0)
                         && (bus.wr_addr0 == bus.wr_addr1);
   assign we0          = run && bus.wr_en0 && addr_ok(bus.wr_addr0);
   // Port 1 is suppressed on a collision so port 0's data is what lands.
   assign we1          = run && bus.wr_en1 && addr_ok(bus.wr_addr1) && !conflict_nxt;
   assign set_ok       = run && bus.sb_set && addr_ok(bus.sb_set_addr);

   always_comb begin
      sb_nxt = sb;
      if (we0)    sb_nxt[bus.wr_addr0]    = 1'b0;
      if (we1)    sb_nxt[bus.wr_addr1]    = 1'b0;
      if (set_ok) sb_nxt[bus.sb_set_addr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_INIT;
         cnt      <= '0;
         sb       <= '0;
         conflict <= 1'b0;
      end else begin
         conflict <= conflict_nxt;
         sb       <= sb_nxt;
         if (state == ST_INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= ST_RUN;
         end
      end
   end

   // Storage carries no reset; contents are hidden until the sweep has rewritten them all.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (!run) begin
            mem[cnt] <= (INIT_INDEX != 0) ? WORD_LEN'(cnt) : '0;
         end else begin
            if (we1) mem[bus.wr_addr1] <= bus.wr_data1;
            if (we0) mem[bus.wr_addr0] <= bus.wr_data0;
         end
      end
   end

   assign ra[0] = bus.rd_addr_a;
   assign ra[1] = bus.rd_addr_b;
   assign ra[2] = bus.rd_addr_c;

   always_comb begin
      for (int p = 0; p < 3; p++) begin
         rd[p] = '0;
         pd[p] = 1'b0;
         if (run && addr_ok(ra[p])) begin
            if (bus.wr_en0 && bus.wr_addr0 == ra[p])      rd[p] = bus.wr_data0;
            else if (bus.wr_en1 && bus.wr_addr1 == ra[p]) rd[p] = bus.wr_data1;
            else                                          rd[p] = mem[ra[p]];
            pd[p] = sb[ra[p]] && !((bus.wr_en0 && bus.wr_addr0 == ra[p]) ||
                                   (bus.wr_en1 && bus.wr_addr1 == ra[p]));
         end
      end
   end

   assign bus.rd_data_a   = rd[0];
   assign bus.rd_data_b   = rd[1];
   assign bus.rd_data_c   = rd[2];
   assign bus.rd_pend_a   = pd[0];
   assign bus.rd_pend_b   = pd[1];
   assign bus.rd_pend_c   = pd[2];
   assign bus.init_busy   = (state == ST_INIT);
   assign bus.wr_conflict = conflict;
endmodule

// File: tb/tb_multiport_reg_file.sv
// Randomized and directed checks of multiport_reg_file against a behavioural model;
// a second instance covers a non-power-of-two register count with zero init.
module tb_multiport_reg_file;
   localparam int WL  = 32;
   localparam int AL  = 4;
   localparam int WC  = 16;
   localparam int WCB = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic rst_b;

   multiport_reg_file_if #(.WORD_LEN(WL), .ADDR_LEN(AL)) bus_a ();
   multiport_reg_file_if #(.WORD_LEN(WL), .ADDR_LEN(AL)) bus_b ();

   multiport_reg_file #(.WORD_LEN(WL), .WORD_COUNT(WC), .ADDR_LEN(AL), .INIT_INDEX(1)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a));
   multiport_reg_file #(.WORD_LEN(WL), .WORD_COUNT(WCB), .ADDR_LEN(AL), .INIT_INDEX(0)) dut_b (
      .clk(clk), .rst(rst_b), .bus(bus_b));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: whole array filled at once when the sweep time has elapsed.
   logic [WL-1:0] m_mem [WC];
   logic [WC-1:0] m_sb   = '0;
   int            m_left = WC;
   logic          m_conf = 1'b0;

   function automatic logic [WL-1:0] exp_data(input logic [AL-1:0] a);
      if (m_left != 0) return '0;
      if (bus_a.wr_en0 && bus_a.wr_addr0 == a) return bus_a.wr_data0;
      if (bus_a.wr_en1 && bus_a.wr_addr1 == a) return bus_a.wr_data1;
      return m_mem[a];
   endfunction

   function automatic logic exp_pend(input logic [AL-1:0] a);
      if (m_left != 0) return 1'b0;
      return m_sb[a] && !((bus_a.wr_en0 && bus_a.wr_addr0 == a) ||
                          (bus_a.wr_en1 && bus_a.wr_addr1 == a));
   endfunction

   task automatic check_a(input string tag);
      logic [AL-1:0] ra [3];
      logic [WL-1:0] gd [3];
      logic          gp [3];
      ra[0] = bus_a.rd_addr_a; ra[1] = bus_a.rd_addr_b; ra[2] = bus_a.rd_addr_c;
      gd[0] = bus_a.rd_data_a; gd[1] = bus_a.rd_data_b; gd[2] = bus_a.rd_data_c;
      gp[0] = bus_a.rd_pend_a; gp[1] = bus_a.rd_pend_b; gp[2] = bus_a.rd_pend_c;
      check({tag, "/busy"}, 32'(bus_a.init_busy), 32'(m_left != 0));
      check({tag, "/conflict"}, 32'(bus_a.wr_conflict), 32'(m_conf));
      for (int p = 0; p < 3; p++) begin
         check($sformatf("%s/data%0d@%0d", tag, p, ra[p]), gd[p], exp_data(ra[p]));
         check($sformatf("%s/pend%0d@%0d", tag, p, ra[p]), 32'(gp[p]), 32'(exp_pend(ra[p])));
      end
   endtask

   task automatic tick_a();
      @(posedge clk);
      if (rst) begin
         m_left = WC;
         m_sb   = '0;
         m_conf = 1'b0;
      end else if (m_left != 0) begin
         m_left--;
         m_conf = 1'b0;
         if (m_left == 0)
            for (int i = 0; i < WC; i++) m_mem[i] = WL'(i);
      end else begin
         m_conf = bus_a.wr_en0 && bus_a.wr_en1 && (bus_a.wr_addr0 == bus_a.wr_addr1);
         if (bus_a.wr_en1) m_mem[bus_a.wr_addr1] = bus_a.wr_data1;
         if (bus_a.wr_en0) m_mem[bus_a.wr_addr0] = bus_a.wr_data0;
         if (bus_a.wr_en0) m_sb[bus_a.wr_addr0] = 1'b0;
         if (bus_a.wr_en1) m_sb[bus_a.wr_addr1] = 1'b0;
         if (bus_a.sb_set) m_sb[bus_a.sb_set_addr] = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic step_a(input string tag);
      #1;
      check_a(tag);
      tick_a();
   endtask

   task automatic idle_a();
      bus_a.wr_en0 = 1'b0; bus_a.wr_addr0 = '0; bus_a.wr_data0 = '0;
      bus_a.wr_en1 = 1'b0; bus_a.wr_addr1 = '0; bus_a.wr_data1 = '0;
      bus_a.sb_set = 1'b0; bus_a.sb_set_addr = '0;
   endtask

   function automatic logic [AL-1:0] pick_addr();
      return ($urandom_range(0, 1) == 0) ? AL'($urandom_range(0, 3)) : AL'($urandom_range(0, WC - 1));
   endfunction

   task automatic rand_a();
      bus_a.wr_en0      = 1'($urandom_range(0, 1));
      bus_a.wr_addr0    = pick_addr();
      bus_a.wr_data0    = $urandom;
      bus_a.wr_en1      = 1'($urandom_range(0, 1));
      bus_a.wr_addr1    = pick_addr();
      bus_a.wr_data1    = $urandom;
      bus_a.sb_set      = ($urandom_range(0, 2) == 0);
      bus_a.sb_set_addr = pick_addr();
      bus_a.rd_addr_a   = pick_addr();
      bus_a.rd_addr_b   = pick_addr();
      bus_a.rd_addr_c   = pick_addr();
   endtask

   task automatic sweep_a(input string tag);
      int busy_cnt;
      busy_cnt = 0;
      for (int i = 0; i < WC; i++) begin
         rand_a();
         #1;
         busy_cnt += int'(bus_a.init_busy);
         step_a(tag);
      end
      idle_a();
      #1;
      check({tag, "/init_len"}, 32'(busy_cnt), 32'(WC));
      for (int i = 0; i < WC; i += 3) begin
         bus_a.rd_addr_a = AL'(i);
         bus_a.rd_addr_b = AL'((i + 1) % WC);
         bus_a.rd_addr_c = AL'((i + 2) % WC);
         #1;
         check($sformatf("%s/init_val%0d", tag, i), bus_a.rd_data_a, WL'(i));
         step_a({tag, "/post"});
      end
   endtask

   initial begin
      rst = 1'b1; rst_b = 1'b1;
      idle_a();
      bus_a.rd_addr_a = '0; bus_a.rd_addr_b = '0; bus_a.rd_addr_c = '0;
      bus_b.wr_en0 = 1'b0; bus_b.wr_addr0 = '0; bus_b.wr_data0 = '0;
      bus_b.wr_en1 = 1'b0; bus_b.wr_addr1 = '0; bus_b.wr_data1 = '0;
      bus_b.sb_set = 1'b0; bus_b.sb_set_addr = '0;
      bus_b.rd_addr_a = '0; bus_b.rd_addr_b = '0; bus_b.rd_addr_c = '0;
      tick_a();
      #1 check("rst_busy", 32'(bus_a.init_busy), 32'd1);
      check("rst_conflict", 32'(bus_a.wr_conflict), 32'd0);
      rst = 1'b0;
      sweep_a("sweep1");

      idle_a();
      bus_a.rd_addr_a = 4'd5;
      #1;
      check("idx5_data", bus_a.rd_data_a, 32'd5);
      check("idx5_pend", 32'(bus_a.rd_pend_a), 32'd0);
      step_a("idx5");

      bus_a.wr_en0 = 1'b1; bus_a.wr_addr0 = 4'd3; bus_a.wr_data0 = 32'hDEAD_BEEF;
      bus_a.rd_addr_b = 4'd3;
      #1 check("bypass_b", bus_a.rd_data_b, 32'hDEAD_BEEF);
      step_a("bypass");
      idle_a();
      #1 check("stored_b", bus_a.rd_data_b, 32'hDEAD_BEEF);
      step_a("stored");

      bus_a.wr_en0 = 1'b1; bus_a.wr_addr0 = 4'd7; bus_a.wr_data0 = 32'h11;
      bus_a.wr_en1 = 1'b1; bus_a.wr_addr1 = 4'd7; bus_a.wr_data1 = 32'h22;
      bus_a.rd_addr_a = 4'd7;
      step_a("collide");
      idle_a();
      #1;
      check("collide_win", bus_a.rd_data_a, 32'h11);
      check("collide_pulse", 32'(bus_a.wr_conflict), 32'd1);
      step_a("collide1");
      #1 check("collide_end", 32'(bus_a.wr_conflict), 32'd0);
      step_a("collide2");

      bus_a.sb_set = 1'b1; bus_a.sb_set_addr = 4'd4; bus_a.rd_addr_c = 4'd4;
      step_a("sb_set");
      idle_a();
      #1 check("sb_pend", 32'(bus_a.rd_pend_c), 32'd1);
      bus_a.wr_en1 = 1'b1; bus_a.wr_addr1 = 4'd4; bus_a.wr_data1 = 32'h44;
      #1 check("sb_mask", 32'(bus_a.rd_pend_c), 32'd0);
      step_a("sb_clr");
      idle_a();
      #1 check("sb_cleared", 32'(bus_a.rd_pend_c), 32'd0);
      bus_a.sb_set = 1'b1; bus_a.sb_set_addr = 4'd4;
      bus_a.wr_en0 = 1'b1; bus_a.wr_addr0 = 4'd4; bus_a.wr_data0 = 32'h55;
      step_a("sb_both");
      idle_a();
      #1 check("sb_set_wins", 32'(bus_a.rd_pend_c), 32'd1);
      step_a("sb_after");

      // Restart the sweep part way through.
      rst = 1'b1;
      step_a("rst2");
      rst = 1'b0;
      for (int i = 0; i < 9; i++) begin
         rand_a();
         step_a("part_sweep");
      end
      rst = 1'b1;
      rand_a();
      step_a("rst_mid");
      rst = 1'b0;
      sweep_a("sweep2");

      for (int i = 0; i < 600; i++) begin
         rand_a();
         rst = ($urandom_range(0, 199) == 0);
         step_a("rand");
      end
      rst = 1'b0;
      idle_a();
      for (int i = 0; i < WC + 2; i++) step_a("drain");

      // Twelve-register instance with zero init.
      @(posedge clk);
      @(negedge clk);
      rst_b = 1'b0;
      for (int i = 0; i < WCB; i++) begin
         bus_b.wr_en0 = 1'b1; bus_b.wr_addr0 = AL'(i); bus_b.wr_data0 = $urandom | 32'h1;
         bus_b.rd_addr_a = AL'(i);
         #1;
         check($sformatf("b_busy%0d", i), 32'(bus_b.init_busy), 32'd1);
         check($sformatf("b_init_rd%0d", i), bus_b.rd_data_a, 32'd0);
         @(posedge clk);
         @(negedge clk);
      end
      bus_b.wr_en0 = 1'b0;
      bus_b.rd_addr_a = 4'd11; bus_b.rd_addr_b = 4'd2; bus_b.rd_addr_c = 4'd0;
      #1;
      check("b_done", 32'(bus_b.init_busy), 32'd0);
      check("b_rd11", bus_b.rd_data_a, 32'd0);
      check("b_rd2", bus_b.rd_data_b, 32'd0);
      check("b_rd0", bus_b.rd_data_c, 32'd0);
      bus_b.wr_en0 = 1'b1; bus_b.wr_addr0 = 4'd14; bus_b.wr_data0 = 32'hAAAA_5555;
      bus_b.wr_en1 = 1'b1; bus_b.wr_addr1 = 4'd14; bus_b.wr_data1 = 32'h1234_5678;
      bus_b.sb_set = 1'b1; bus_b.sb_set_addr = 4'd14;
      bus_b.rd_addr_a = 4'd14;
      #1;
      check("b_rd14_bypass", bus_b.rd_data_a, 32'd0);
      check("b_pend14_bypass", 32'(bus_b.rd_pend_a), 32'd0);
      @(posedge clk);
      @(negedge clk);
      bus_b.wr_en0 = 1'b1; bus_b.wr_addr0 = 4'd11; bus_b.wr_data0 = 32'h77;
      bus_b.wr_en1 = 1'b0; bus_b.sb_set = 1'b0;
      bus_b.rd_addr_a = 4'd14; bus_b.rd_addr_b = 4'd2; bus_b.rd_addr_c = 4'd10;
      #1;
      check("b_rd14", bus_b.rd_data_a, 32'd0);
      check("b_pend14", 32'(bus_b.rd_pend_a), 32'd0);
      check("b_alias2", bus_b.rd_data_b, 32'd0);
      check("b_rd10", bus_b.rd_data_c, 32'd0);
      @(posedge clk);
      @(negedge clk);
      bus_b.wr_en0 = 1'b0;
      bus_b.rd_addr_a = 4'd11;
      #1 check("b_wr11", bus_b.rd_data_a, 32'h77);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/multiport_reg_file.md
MULTIPORT_REG_FILE -- requirements
Module: multiport_reg_file

Interface
REQ-001 The block SHALL expose the following parameters, one per line: name, default, meaning.
  WORD_LEN  32  data width in bits
  WORD_COUNT  16  number of registers, 2..2^ADDR_LEN
  ADDR_LEN  4  address width in bits
  INIT_INDEX  1  1: init value = register index; 0: init value = 0
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
  clk  in  1  clock; all state updates on rising edge
  rst  in  1  reset, synchronous, active-high
  init_busy  out  1  init sweep in progress
  rd_addr_a/b/c  in  ADDR_LEN  read addresses (Rn, Rm, Rs)
  rd_data_a/b/c  out  WORD_LEN  read data, combinational
  rd_pend_a/b/c  out  1  scoreboard pending bit for the read address
  wr_en0, wr_addr0, wr_data0  in  1/ADDR_LEN/WORD_LEN  primary write port (result writeback)
  wr_en1, wr_addr1, wr_data1  in  1/ADDR_LEN/WORD_LEN  secondary write port (base writeback)
  sb_set, sb_set_addr  in  1/ADDR_LEN  mark a register pending (producer issued)
  wr_conflict  out  1  registered pulse: both ports wrote the same address

Function
REQ-003 The block SHALL implement a two-state FSM, INIT and RUN; init_busy SHALL be 1 exactly in INIT.
REQ-004 In INIT, each rising edge with rst=0 SHALL write reg[cnt] <= (INIT_INDEX ? cnt : 0) and increment cnt; the edge that writes index WORD_COUNT-1 SHALL move the FSM to RUN.
REQ-005 The init sweep SHALL take exactly WORD_COUNT cycles after rst deasserts.
REQ-006 In INIT, wr_en0, wr_en1 and sb_set SHALL be ignored, rd_data_* SHALL read 0, and rd_pend_* SHALL read 0.
REQ-007 In RUN, an asserted wr_enN SHALL write wr_dataN to wr_addrN at the rising edge.
REQ-008 If wr_en0 and wr_en1 target the same address, port 0 SHALL win, and wr_conflict SHALL be 1 for the following cycle only; otherwise wr_conflict SHALL be 0.
REQ-009 Reads SHALL be combinational with write-through bypass: if wr_en0 matches rd_addr, return wr_data0; else if wr_en1 matches, return wr_data1; else return the array value.
REQ-010 The scoreboard SHALL be WORD_COUNT bits; sb_set SHALL set bit[sb_set_addr] at the edge, and any RUN write SHALL clear bit[wr_addrN] at the edge.
REQ-011 If set and clear hit the same address on the same edge, set SHALL win.
REQ-012 rd_pend_x SHALL equal sb[rd_addr_x] AND NOT (any enabled write port matching rd_addr_x).
REQ-013 For any address >= WORD_COUNT: writes and sb_set SHALL be ignored, reads SHALL return 0, and rd_pend SHALL be 0.
REQ-014 All three read ports SHALL be independent, and any port may read any address simultaneously.

Reset
REQ-015 An edge with rst=1 SHALL force state=INIT, cnt=0, scoreboard=0 and wr_conflict=0; init_busy SHALL be 1 from that edge on.
REQ-016 rst asserted mid-sweep or in RUN SHALL restart the sweep at index 0; in-flight writes on that edge SHALL be discarded.
REQ-017 Register contents before sweep completion SHALL NOT be observable (see REQ-006).

Verification
REQ-018 Default params, rst 1 cycle then 0 -> init_busy=1 for 16 cycles then 0; afterwards rd_addr_a=5 -> rd_data_a=5 and rd_pend_a=0.
REQ-019 RUN, wr_en0=1, addr 3, data 0xDEAD_BEEF, rd_addr_b=3 in the same cycle -> rd_data_b=0xDEADBEEF before the edge; after the edge, with wr_en0=0, it still reads 0xDEADBEEF.
REQ-020 wr_en0 addr 7 data 0x11 and wr_en1 addr 7 data 0x22 on the same edge -> reg7=0x11; wr_conflict=1 for exactly one cycle.
REQ-021 sb_set addr 4 -> rd_pend_c(4)=1; next cycle wr_en1 addr 4 -> rd_pend_c=0 combinationally in that cycle; bit cleared after the edge; sb_set and a write to addr 4 on the same edge -> bit stays 1.
REQ-022 rst pulsed at sweep cycle 9 -> init_busy stays 1 for a further 16 cycles, and writes attempted during the sweep have no effect.
REQ-023 WORD_COUNT=12, INIT_INDEX=0: write to addr 14 ignored; read of addr 14 = 0; read of addr 11 after init = 0.
